// File: rtl/stopwatch_lap_ctrl.sv
// Stopwatch controller: button synchronisers and edge detectors, a run/pause/lap/done
// FSM, an up/down time counter with wrap and expiry, and a lap hold register.
module stopwatch_lap_ctrl #(
  parameter int CNT_W       = 16,
  parameter int MAX_COUNT   = 59999,
  parameter int SYNC_STAGES = 2      // must be at least 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             start_stop,
  input  logic             lap,
  input  logic             clr_btn,
  input  logic             mode_down,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] display,
  output logic             running,
  output logic             expired,
  output logic [2:0]       state_o
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_PAUSE = 3'd2,
    ST_LAP   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] MAX_VAL = CNT_W'(MAX_COUNT);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] lap_q, lap_d;
  logic             mode_q, mode_d;

  // Button conditioning: bit 0 = start/stop, bit 1 = lap, bit 2 = clear
  logic [2:0] btn_raw;
  logic [2:0] btn_pulse;
  logic       ss_p, lap_p, clr_p;

  assign btn_raw = {clr_btn, lap, start_stop};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_btn
      logic [SYNC_STAGES-1:0] sync_q;
      logic                   prev_q;

      // Synchroniser chain plus one flop of history for rising-edge detection
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          sync_q <= '0;
          prev_q <= 1'b0;
        end else begin
          sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw[gi]};
          prev_q <= sync_q[SYNC_STAGES-1];
        end
      end

      assign btn_pulse[gi] = sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  endgenerate

  assign ss_p  = btn_pulse[0];
  assign lap_p = btn_pulse[1];
  assign clr_p = btn_pulse[2];

  // Countdown start value, clamped so the counter never leaves 0..MAX_COUNT
  logic [CNT_W-1:0] load_clamped;
  assign load_clamped = (load_val > MAX_VAL) ? MAX_VAL : load_val;

  // Counter value a running stopwatch would reach this cycle, plus down-mode expiry
  logic [CNT_W-1:0] cnt_run;
  logic             expire_hit;

  always_comb begin
    cnt_run    = count_q;
    expire_hit = 1'b0;
    if (tick) begin
      if (mode_q) begin
        // Reaching zero (or already there) ends the countdown
        if (count_q <= ONE) begin
          cnt_run    = '0;
          expire_hit = 1'b1;
        end else begin
          cnt_run = count_q - ONE;
        end
      end else begin
        cnt_run = (count_q == MAX_VAL) ? '0 : count_q + ONE;
      end
    end
  end

  // Next-state, counter, lap-hold and mode-latch logic; clear beats start/stop beats lap
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    lap_d   = lap_q;
    mode_d  = mode_q;

    case (state_q)
      ST_IDLE: begin
        count_d = mode_down ? load_clamped : '0;
        if (clr_p) begin
          state_d = ST_IDLE;
        end else if (ss_p) begin
          mode_d  = mode_down;
          state_d = (mode_down && (load_clamped == '0)) ? ST_DONE : ST_RUN;
        end
      end

      ST_RUN, ST_LAP: begin
        count_d = cnt_run;
        if (clr_p) begin
          state_d = ST_IDLE;
        end else if (expire_hit) begin
          state_d = ST_DONE;
        end else if (ss_p) begin
          state_d = ST_PAUSE;
        end else if (lap_p) begin
          if (state_q == ST_RUN) begin
            state_d = ST_LAP;
            lap_d   = cnt_run;   // snapshot includes this cycle's tick
          end else begin
            state_d = ST_RUN;
          end
        end
      end

      ST_PAUSE: begin
        if (clr_p) begin
          state_d = ST_IDLE;
        end else if (ss_p) begin
          state_d = ST_RUN;
        end
      end

      ST_DONE: begin
        count_d = '0;
        if (clr_p || ss_p) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      lap_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      lap_q   <= lap_d;
      mode_q  <= mode_d;
    end
  end

  assign count   = count_q;
  assign display = (state_q == ST_LAP) ? lap_q : count_q;
  assign running = (state_q == ST_RUN) || (state_q == ST_LAP);
  assign expired = (state_q == ST_DONE);
  assign state_o = state_q;

endmodule

// File: tb/tb_stopwatch_lap_ctrl.sv
// Self-checking bench for stopwatch_lap_ctrl using an expectation queue.
module tb_stopwatch_lap_ctrl;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             tick;
  logic             start_stop;
  logic             lap;
  logic             clr_btn;
  logic             mode_down;
  logic [CNT_W-1:0] load_val;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] display;
  logic             running;
  logic             expired;
  logic [2:0]       state_o;

  int checks_cnt = 0;
  int errors_cnt = 0;

  typedef struct {
    string       tag;
    int          sel;    // 0 count, 1 display, 2 running, 3 expired, 4 state
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];

  stopwatch_lap_ctrl #(
    .CNT_W(16), .MAX_COUNT(59999), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .start_stop(start_stop),
    .lap(lap), .clr_btn(clr_btn), .mode_down(mode_down), .load_val(load_val),
    .count(count), .display(display), .running(running), .expired(expired),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s = %0d", tag, obs);
    end
  endtask

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      0:       return 32'(count);
      1:       return 32'(display);
      2:       return 32'(running);
      3:       return 32'(expired);
      default: return 32'(state_o);
    endcase
  endfunction

  task automatic expect_val(input string tag, input int sel, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  // Pop every pending expectation and compare against the DUT as it stands now
  task automatic sb_check();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk(e.tag, observe(e.sel), e.exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_ticks(input int n);
    tick = 1'b1;
    repeat (n) step();
    tick = 1'b0;
  endtask

  // One-cycle press; the state reacts on the third edge. tick_last drives tick on that edge.
  task automatic press(input logic [2:0] mask, input logic tick_last);
    {clr_btn, lap, start_stop} = mask;
    step();
    {clr_btn, lap, start_stop} = 3'b000;
    step();
    tick = tick_last;
    step();
    tick = 1'b0;
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; start_stop = 1'b0; lap = 1'b0; clr_btn = 1'b0;
    mode_down = 1'b0; load_val = '0;
    #1;
    expect_val("rst_count", 0, 0); expect_val("rst_display", 1, 0);
    expect_val("rst_running", 2, 0); expect_val("rst_expired", 3, 0);
    expect_val("rst_state", 4, 0);
    sb_check();
    step(); step();
    reset = 1'b0;
    step();

    // IDLE preload and clamp
    mode_down = 1'b1; load_val = 16'hFFFF; step();
    expect_val("clamp_count", 0, 59999); expect_val("clamp_display", 1, 59999); sb_check();
    load_val = 16'd3; step();
    expect_val("load3_count", 0, 3); sb_check();
    mode_down = 1'b0; step();
    expect_val("upmode_idle_count", 0, 0); sb_check();

    // Up count, pause, tick timing on transitions
    press(3'b001, 1'b0);
    expect_val("start_state", 4, 1); expect_val("start_running", 2, 1); sb_check();
    do_ticks(5);
    expect_val("up5_count", 0, 5); sb_check();
    press(3'b001, 1'b0);
    expect_val("pause_state", 4, 2); expect_val("pause_running", 2, 0); sb_check();
    do_ticks(3);
    expect_val("pause_hold_count", 0, 5); sb_check();
    press(3'b001, 1'b1);
    expect_val("resume_state", 4, 1); expect_val("resume_tick_ignored", 0, 5); sb_check();
    press(3'b001, 1'b1);
    expect_val("pause2_state", 4, 2); expect_val("pause_tick_counted", 0, 6); sb_check();
    press(3'b100, 1'b0);
    expect_val("clr_pause_state", 4, 0); sb_check();
    step();
    expect_val("clr_count", 0, 0); sb_check();

    // Lap hold
    press(3'b001, 1'b0);
    do_ticks(10);
    expect_val("lap_pre_count", 0, 10); sb_check();
    press(3'b010, 1'b0);
    expect_val("lap_state", 4, 3); expect_val("lap_display", 1, 10);
    expect_val("lap_running", 2, 1); sb_check();
    do_ticks(4);
    expect_val("lap_hold_display", 1, 10); expect_val("lap_live_count", 0, 14); sb_check();
    press(3'b010, 1'b0);
    expect_val("unlap_state", 4, 1); expect_val("unlap_display", 1, 14); sb_check();
    press(3'b010, 1'b1);
    expect_val("lap_tick_state", 4, 3); expect_val("lap_tick_display", 1, 15); sb_check();
    press(3'b010, 1'b0);
    do_ticks(22);
    expect_val("prereset_count", 0, 37); expect_val("prereset_state", 4, 1); sb_check();

    // Asynchronous reset mid-run
    reset = 1'b1;
    #2;
    expect_val("async_rst_count", 0, 0); expect_val("async_rst_display", 1, 0);
    expect_val("async_rst_running", 2, 0); expect_val("async_rst_state", 4, 0); sb_check();
    step();
    reset = 1'b0;
    step();

    // Up-count wrap at MAX_COUNT
    press(3'b001, 1'b0);
    do_ticks(59999);
    expect_val("wrap_pre_count", 0, 59999); sb_check();
    do_ticks(1);
    expect_val("wrap_count", 0, 0); expect_val("wrap_state", 4, 1); sb_check();
    press(3'b100, 1'b0);
    expect_val("clr_run_state", 4, 0); sb_check();

    // Countdown to expiry; mode change outside IDLE ignored
    mode_down = 1'b1; load_val = 16'd3; step();
    expect_val("down_load", 0, 3); sb_check();
    press(3'b001, 1'b0);
    expect_val("down_start_state", 4, 1); expect_val("down_start_count", 0, 3); sb_check();
    mode_down = 1'b0;
    do_ticks(1); expect_val("down_2", 0, 2); sb_check();
    do_ticks(1); expect_val("down_1", 0, 1); sb_check();
    do_ticks(1);
    expect_val("down_0", 0, 0); expect_val("done_state", 4, 4);
    expect_val("done_expired", 3, 1); expect_val("done_running", 2, 0); sb_check();
    do_ticks(2);
    expect_val("done_hold_count", 0, 0); expect_val("done_hold_state", 4, 4); sb_check();
    mode_down = 1'b1;
    press(3'b001, 1'b0);
    expect_val("done_exit_state", 4, 0); expect_val("done_exit_expired", 3, 0); sb_check();
    step();
    expect_val("reload_count", 0, 3); sb_check();

    // Zero load goes straight to DONE
    load_val = '0; step();
    press(3'b001, 1'b0);
    expect_val("zero_load_state", 4, 4); sb_check();
    press(3'b001, 1'b0);
    expect_val("zero_load_exit", 4, 0); sb_check();

    // Simultaneous buttons: clear wins, on the third edge only
    mode_down = 1'b0; step();
    press(3'b001, 1'b0);
    do_ticks(3);
    {clr_btn, lap, start_stop} = 3'b111;
    step(); step();
    expect_val("prio_before_state", 4, 1); sb_check();
    step();
    expect_val("prio_state", 4, 0); expect_val("prio_running", 2, 0); sb_check();
    step(); step(); step();
    expect_val("prio_held_state", 4, 0); sb_check();
    {clr_btn, lap, start_stop} = 3'b000;
    step(); step(); step();

    // Held start/stop yields a single transition
    start_stop = 1'b1;
    repeat (3) step();
    expect_val("hold_start_state", 4, 1); sb_check();
    repeat (17) step();
    expect_val("hold_still_run", 4, 1); sb_check();
    start_stop = 1'b0;
    repeat (4) step();
    expect_val("hold_release_run", 4, 1); sb_check();

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule

// File: doc/stopwatch_lap_ctrl.md
Name: stopwatch_lap_ctrl

Overview:
Second-generation stopwatch controller that merges the run/pause FSM with its own time counter. Adds on-chip button synchronisation and edge detection, a lap/split hold, and a countdown mode with expiry. It sits between the raw front-panel buttons and the display formatter, and consumes a one-cycle count tick from the prescaler.

Parameters:
CNT_W, 16, width of count, display and load_val
MAX_COUNT, 59999, highest count value; up-count wraps from here to 0; load_val is clamped to it
SYNC_STAGES, 2, synchroniser flops per button input (minimum 2)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
tick  in  1  one-cycle count enable from the prescaler
start_stop  in  1  raw start/stop button, asynchronous level
lap  in  1  raw lap button, asynchronous level
clr_btn  in  1  raw clear button, asynchronous level
mode_down  in  1  1 = countdown, 0 = count-up; sampled in IDLE only
load_val  in  CNT_W  countdown start value
count  out  CNT_W  live counter value
display  out  CNT_W  value to be shown (lap value while in LAP)
running  out  1  high in RUN or LAP
expired  out  1  high in DONE
state_o  out  3  current state encoding

Behaviour:
- Reset (asynchronous): state=IDLE, count=0, lap_reg=0, all synchroniser/edge flops=0, mode latch=0. Resulting outputs: running=0, expired=0, display=0, state_o=0.
- Button conditioning: each button passes through SYNC_STAGES flops, then a rising-edge detector produces internal pulses ss_p, lap_p and clr_p.
  - Pulse = sync_out & ~sync_prev.
  - A button sampled high at edge 1 affects the state at edge SYNC_STAGES+1.
  - Holding a button produces exactly one pulse.
- State encoding: IDLE=0, RUN=1, PAUSE=2, LAP=3, DONE=4. state_o=5..7 is unreachable; if it occurs, the next state is IDLE.
- Event priority per cycle: clr_p > ss_p > lap_p.
- clr_p from any state: next state IDLE.
- IDLE:
  - count <= (mode_down ? min(load_val, MAX_COUNT) : 0) every cycle.
  - ss_p: latch mode_down into the mode latch. If the latched mode is down and the loaded value is 0, go to DONE; otherwise go to RUN.
  - lap_p ignored.
- RUN:
  - tick: up mode gives count+1, wrapping MAX_COUNT to 0. Down mode gives count-1.
  - Down mode with tick while count==1: count <= 0, next state DONE.
  - ss_p -> PAUSE.
  - lap_p -> LAP, with lap_reg <= the count value resulting from this cycle (post-tick).
- LAP:
  - Counting continues exactly as in RUN.
  - display=lap_reg.
  - lap_p -> RUN (display goes live again).
  - ss_p -> PAUSE.
  - Down-mode expiry -> DONE.
- PAUSE:
  - count holds; tick ignored.
  - ss_p -> RUN.
  - lap_p ignored.
- DONE:
  - count holds 0; expired=1.
  - ss_p -> IDLE.
  - lap_p ignored.
- Tick timing:
  - A tick in the same cycle as a RUN->PAUSE transition is counted; the update is based on the current state.
  - A tick in the same cycle as IDLE->RUN or PAUSE->RUN is not counted.
- Mode latch: changes to mode_down outside IDLE are ignored.
- Output decode: display = (state==LAP) ? lap_reg : count. running, expired and state_o are combinational decodes of registered state; there is no extra latency.
- Width rules: all arithmetic is CNT_W-bit unsigned. MAX_COUNT must be less than 2**CNT_W.

Test Plan:
1. Reset asserted mid-RUN with count=37 -> all outputs return to 0 immediately (asynchronously); state_o=0.
2. Up mode: start_stop pulse, then 5 ticks, then start_stop -> state RUN, count=5, then PAUSE. Further ticks leave count=5.
3. Up-mode wrap: count preset near 59999 (reach it by running), one tick at 59999 -> count=0, state stays RUN.
4. Lap: in RUN at count=10, lap pulse with no tick in that cycle, then 4 ticks -> display=10 and count=14. A second lap pulse -> display=14.
5. Countdown: mode_down=1, load_val=3, start, 3 ticks -> count 2, 1, 0, then DONE with expired=1. start_stop -> IDLE, count reloads 3.
6. Priority and sync: start_stop, lap and clr_btn raised in the same cycle during RUN -> exactly one transition, to IDLE, at edge SYNC_STAGES+1. Holding start_stop high for 20 cycles in IDLE -> a single IDLE->RUN.
